// File: rtl/rx_phy_assembler.sv
// rx_phy_assembler: receive reconciliation block. Takes RMII/MII/GMII beats
// qualified by phy_ce, hunts for the SFD at beat granularity, assembles bytes
// LSB-first and reports a per-frame status word on rx_eof.
module rx_phy_assembler #(
  parameter bit ALIGN_SFD  = 1'b1,
  parameter bit RAW_STATUS = 1'b0
) (
  input  logic       clk_125,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic       phy_ce,
  input  logic [7:0] phy_rxd,
  input  logic       phy_rxdv,
  input  logic       phy_rxer,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_er,
  output logic       rx_eof,
  output logic       rx_frame_err,
  output logic [2:0] rx_status
);

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;
  typedef enum logic [1:0] {LANE_RMII = 2'b00, LANE_MII = 2'b01, LANE_GMII = 2'b10} lane_t;

  state_t      state, nxt;
  lane_t       lane_q, eff_lane;
  logic [1:0]  idx, last_idx;
  logic [7:0]  sreg, merged;
  logic [3:0]  prev;
  logic        byte_er, frame_er, first;
  logic        start, data_beat, complete, sfd_hit, term, sfd_match;
  logic        first_eff, byte_er_eff;
  logic [2:0]  status;

  function automatic lane_t norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? LANE_GMII : lane_t'(m);
  endfunction

  // State register
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // Next-state logic; only phy_ce beats can move the FSM
  always_comb begin
    nxt = state;
    if (phy_ce) begin
      unique case (state)
        IDLE:    if (phy_rxdv) nxt = ALIGN_SFD ? HUNT : DATA;
        HUNT:    if (!phy_rxdv) nxt = IDLE;
                 else if (sfd_match) nxt = DATA;
        DATA:    if (!phy_rxdv) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Beat decode: lane width, SFD match, byte merge and end-of-frame status.
  // In IDLE the live mode input is used so that, without SFD alignment, the
  // initiating beat can already be assembled as data beat 0.
  always_comb begin
    eff_lane  = (state == IDLE) ? norm_mode(mode) : lane_q;
    last_idx  = '0;
    merged    = sreg;
    sfd_match = 1'b0;
    case (eff_lane)
      LANE_RMII: begin
        last_idx                 = 2'd3;
        merged[{idx, 1'b0} +: 2] = phy_rxd[1:0];
        sfd_match                = (phy_rxd[1:0] == 2'b11) && (prev[1:0] == 2'b01);
      end
      LANE_MII: begin
        last_idx                     = 2'd1;
        merged[{idx[0], 2'b00} +: 4] = phy_rxd[3:0];
        sfd_match                    = (phy_rxd[3:0] == 4'hD) && (prev == 4'h5);
      end
      default: begin
        last_idx  = 2'd0;
        merged    = phy_rxd;
        sfd_match = (phy_rxd == 8'hD5);
      end
    endcase
    start       = phy_ce && phy_rxdv && (state == IDLE);
    data_beat   = phy_ce && phy_rxdv && ((state == DATA) || ((state == IDLE) && !ALIGN_SFD));
    complete    = data_beat && (idx == last_idx);
    sfd_hit     = phy_ce && phy_rxdv && (state == HUNT) && sfd_match;
    term        = phy_ce && !phy_rxdv && (state != IDLE);
    first_eff   = start ? 1'b1 : first;
    byte_er_eff = start ? 1'b0 : byte_er;
    status      = {state == HUNT, (state == DATA) && (idx != 2'd0), frame_er};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      lane_q       <= LANE_RMII;
      idx          <= '0;
      sreg         <= '0;
      prev         <= '0;
      byte_er      <= 1'b0;
      frame_er     <= 1'b0;
      first        <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_er        <= 1'b0;
      rx_eof       <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_status    <= '0;
    end else begin
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_er        <= 1'b0;
      rx_eof       <= 1'b0;
      rx_frame_err <= 1'b0;
      if (!RAW_STATUS) rx_status <= '0;
      if (phy_ce) prev <= phy_rxd[3:0];
      if (start) begin
        lane_q   <= norm_mode(mode);
        frame_er <= phy_rxer;
        first    <= 1'b1;
        byte_er  <= 1'b0;
        idx      <= '0;
      end else if (phy_ce && phy_rxdv && (state != IDLE)) begin
        frame_er <= frame_er | phy_rxer;
      end
      if (sfd_hit) begin
        idx     <= '0;
        byte_er <= 1'b0;
      end
      if (data_beat) begin
        sreg <= merged;
        if (complete) begin
          rx_data  <= merged;
          rx_valid <= 1'b1;
          rx_sof   <= first_eff;
          rx_er    <= byte_er_eff | phy_rxer;
          first    <= 1'b0;
          idx      <= '0;
          byte_er  <= 1'b0;
        end else begin
          idx     <= idx + 2'd1;
          byte_er <= byte_er_eff | phy_rxer;
        end
      end
      if (term) begin
        rx_eof       <= 1'b1;
        rx_status    <= status;
        rx_frame_err <= |status;
        idx          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_phy_assembler.sv
// Directed testbench for rx_phy_assembler (SFD-aligned instance plus a
// legacy pass-through instance sharing the same PHY inputs).
module tb_rx_phy_assembler;

  logic       clk_125 = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode    = 2'b00;
  logic       phy_ce  = 1'b0;
  logic [7:0] phy_rxd = 8'h00;
  logic       phy_rxdv = 1'b0;
  logic       phy_rxer = 1'b0;

  logic [7:0] rx_data, l_data;
  logic       rx_valid, rx_sof, rx_er, rx_eof, rx_frame_err;
  logic       l_valid, l_sof, l_er, l_eof, l_ferr;
  logic [2:0] rx_status, l_status;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int eof_cnt = 0;
  int overlap_cnt = 0;

  rx_phy_assembler #(.ALIGN_SFD(1'b1), .RAW_STATUS(1'b0)) dut (
    .clk_125(clk_125), .reset_n(reset_n), .mode(mode), .phy_ce(phy_ce),
    .phy_rxd(phy_rxd), .phy_rxdv(phy_rxdv), .phy_rxer(phy_rxer),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_er(rx_er),
    .rx_eof(rx_eof), .rx_frame_err(rx_frame_err), .rx_status(rx_status)
  );

  rx_phy_assembler #(.ALIGN_SFD(1'b0), .RAW_STATUS(1'b0)) dut_legacy (
    .clk_125(clk_125), .reset_n(reset_n), .mode(mode), .phy_ce(phy_ce),
    .phy_rxd(phy_rxd), .phy_rxdv(phy_rxdv), .phy_rxer(phy_rxer),
    .rx_data(l_data), .rx_valid(l_valid), .rx_sof(l_sof), .rx_er(l_er),
    .rx_eof(l_eof), .rx_frame_err(l_ferr), .rx_status(l_status)
  );

  always #5 clk_125 = ~clk_125;

  // Count output pulses of the aligned instance, one sample per cycle
  always @(negedge clk_125) begin
    if (rx_valid) valid_cnt++;
    if (rx_eof) eof_cnt++;
    if (rx_valid && rx_eof) overlap_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // One PHY beat every gap cycles; returns #1 after the edge that registers it
  task automatic beat(input logic [7:0] d, input logic dv, input logic er, input int unsigned gap);
    for (int unsigned i = 1; i < gap; i++) begin
      @(negedge clk_125);
      phy_ce = 1'b0;
    end
    @(negedge clk_125);
    phy_ce   = 1'b1;
    phy_rxd  = d;
    phy_rxdv = dv;
    phy_rxer = er;
    @(posedge clk_125);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk_125);
      phy_ce   = 1'b0;
      phy_rxdv = 1'b0;
      phy_rxer = 1'b0;
    end
    @(posedge clk_125);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_125);
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_sof, rx_er, rx_eof, rx_frame_err, rx_status} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000",
               {rx_data, rx_valid, rx_sof, rx_er, rx_eof, rx_frame_err, rx_status});
    end
    checks++;
    if ({l_data, l_valid, l_sof, l_er, l_eof, l_ferr, l_status} !== 16'h0) begin
      errors++;
      $display("FAIL reset_legacy_outputs: got %h want 0000",
               {l_data, l_valid, l_sof, l_er, l_eof, l_ferr, l_status});
    end
    @(negedge clk_125);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_mii();
    logic [7:0] b [3];
    b = '{8'h01, 8'h02, 8'hA5};
    mode = 2'b01;
    repeat (15) beat(8'h05, 1'b1, 1'b0, 5);
    beat(8'h0D, 1'b1, 1'b0, 5);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL mii_sfd_hidden: valid got %b want 0", rx_valid); end
    for (int i = 0; i < 3; i++) begin
      beat({4'h0, b[i][3:0]}, 1'b1, 1'b0, 5);
      checks++;
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL mii_half_byte[%0d]: valid got %b want 0", i, rx_valid); end
      beat({4'h0, b[i][7:4]}, 1'b1, 1'b0, 5);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== b[i]) begin
        errors++; $display("FAIL mii_byte[%0d]: got v=%b d=%h want v=1 d=%h", i, rx_valid, rx_data, b[i]);
      end
      checks++;
      if (rx_sof !== (i == 0) || rx_er !== 1'b0) begin
        errors++; $display("FAIL mii_flags[%0d]: got sof=%b er=%b want sof=%b er=0", i, rx_sof, rx_er, i == 0);
      end
    end
    beat(8'h00, 1'b0, 1'b0, 5);
    checks++;
    if (rx_eof !== 1'b1 || rx_status !== 3'b000 || rx_frame_err !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL mii_eof: got eof=%b st=%b ferr=%b v=%b want 1 000 0 0", rx_eof, rx_status, rx_frame_err, rx_valid);
    end
    idle(1);
    checks++;
    if (rx_eof !== 1'b0) begin errors++; $display("FAIL mii_eof_pulse: eof got %b want 0", rx_eof); end
  endtask

  task automatic test_rmii_dribble();
    logic [7:0] b [2];
    b = '{8'h3C, 8'h81};
    mode = 2'b00;
    repeat (27) beat(8'h01, 1'b1, 1'b0, 10);
    beat(8'h03, 1'b1, 1'b0, 10);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) beat({6'b0, b[i][2*k +: 2]}, 1'b1, 1'b0, 10);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== b[i] || rx_sof !== (i == 0)) begin
        errors++; $display("FAIL rmii_byte[%0d]: got v=%b d=%h sof=%b want v=1 d=%h sof=%b", i, rx_valid, rx_data, rx_sof, b[i], i == 0);
      end
    end
    beat(8'h02, 1'b1, 1'b0, 10);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmii_partial: valid got %b want 0", rx_valid); end
    beat(8'h00, 1'b0, 1'b0, 10);
    checks++;
    if (rx_eof !== 1'b1 || rx_status !== 3'b010 || rx_frame_err !== 1'b1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL rmii_dribble_eof: got eof=%b st=%b ferr=%b v=%b want 1 010 1 0", rx_eof, rx_status, rx_frame_err, rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3];
    b = '{8'h10, 8'h20, 8'h30};
    mode = 2'b10;
    idle(2);
    repeat (7) beat(8'h55, 1'b1, 1'b0, 1);
    beat(8'hD5, 1'b1, 1'b0, 1);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL gmii_sfd_hidden: valid got %b want 0", rx_valid); end
    for (int i = 0; i < 3; i++) begin
      beat(b[i], 1'b1, i == 1, 1);
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== b[i] || rx_er !== (i == 1) || rx_sof !== (i == 0)) begin
        errors++; $display("FAIL gmii_byte[%0d]: got v=%b d=%h er=%b sof=%b want v=1 d=%h er=%b sof=%b",
                           i, rx_valid, rx_data, rx_er, rx_sof, b[i], i == 1, i == 0);
      end
    end
    beat(8'h00, 1'b0, 1'b0, 1);
    checks++;
    if (rx_eof !== 1'b1 || rx_status !== 3'b001 || rx_frame_err !== 1'b1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL gmii_err_eof: got eof=%b st=%b ferr=%b v=%b want 1 001 1 0", rx_eof, rx_status, rx_frame_err, rx_valid);
    end
    idle(1);
    checks++;
    if (rx_data !== 8'h30) begin errors++; $display("FAIL gmii_data_hold: got %h want 30", rx_data); end
  endtask

  task automatic test_no_sfd();
    int v0;
    mode = 2'b01;
    idle(2);
    v0 = valid_cnt;
    repeat (16) beat(8'h05, 1'b1, 1'b0, 2);
    beat(8'h00, 1'b0, 1'b0, 2);
    checks++;
    if (valid_cnt !== v0) begin errors++; $display("FAIL nosfd_no_bytes: valid pulses got %0d want 0", valid_cnt - v0); end
    checks++;
    if (rx_eof !== 1'b1 || rx_status !== 3'b100 || rx_frame_err !== 1'b1) begin
      errors++; $display("FAIL nosfd_eof: got eof=%b st=%b ferr=%b want 1 100 1", rx_eof, rx_status, rx_frame_err);
    end
  endtask

  task automatic test_mode_switch_and_reset();
    int e0;
    mode = 2'b01;
    idle(2);
    repeat (7) beat(8'h05, 1'b1, 1'b0, 3);
    beat(8'h0D, 1'b1, 1'b0, 3);
    beat(8'h01, 1'b1, 1'b0, 3);
    beat(8'h01, 1'b1, 1'b0, 3);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("FAIL modesw_byte1: got v=%b d=%h want v=1 d=11", rx_valid, rx_data);
    end
    mode = 2'b10;
    beat(8'h02, 1'b1, 1'b0, 3);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL modesw_held_mii: valid got %b want 0", rx_valid); end
    beat(8'h02, 1'b1, 1'b0, 3);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
      errors++; $display("FAIL modesw_byte2: got v=%b d=%h want v=1 d=22", rx_valid, rx_data);
    end
    beat(8'h03, 1'b1, 1'b0, 3);
    e0 = eof_cnt;
    @(negedge clk_125);
    phy_ce  = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, rx_sof, rx_er, rx_eof, rx_frame_err, rx_status} !== 16'h0) begin
      errors++; $display("FAIL midframe_reset_outputs: got %h want 0000",
                         {rx_data, rx_valid, rx_sof, rx_er, rx_eof, rx_frame_err, rx_status});
    end
    repeat (3) @(negedge clk_125);
    reset_n  = 1'b1;
    phy_rxdv = 1'b0;
    idle(3);
    checks++;
    if (eof_cnt !== e0) begin errors++; $display("FAIL midframe_reset_no_eof: eof pulses got %0d want 0", eof_cnt - e0); end
    mode = 2'b01;
    repeat (3) beat(8'h05, 1'b1, 1'b0, 3);
    beat(8'h0D, 1'b1, 1'b0, 3);
    beat(8'h04, 1'b1, 1'b0, 3);
    beat(8'h04, 1'b1, 1'b0, 3);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h44 || rx_sof !== 1'b1) begin
      errors++; $display("FAIL after_reset_byte: got v=%b d=%h sof=%b want v=1 d=44 sof=1", rx_valid, rx_data, rx_sof);
    end
    beat(8'h00, 1'b0, 1'b0, 3);
    checks++;
    if (rx_eof !== 1'b1 || rx_status !== 3'b000) begin
      errors++; $display("FAIL after_reset_eof: got eof=%b st=%b want 1 000", rx_eof, rx_status);
    end
  endtask

  task automatic test_legacy();
    logic [7:0] b [3];
    b = '{8'h55, 8'hD5, 8'h0A};
    mode = 2'b10;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      beat(b[i], 1'b1, 1'b0, 1);
      checks++;
      if (l_valid !== 1'b1 || l_data !== b[i] || l_sof !== (i == 0)) begin
        errors++; $display("FAIL legacy_byte[%0d]: got v=%b d=%h sof=%b want v=1 d=%h sof=%b", i, l_valid, l_data, l_sof, b[i], i == 0);
      end
    end
    beat(8'h00, 1'b0, 1'b0, 1);
    checks++;
    if (l_eof !== 1'b1 || l_status !== 3'b000 || l_valid !== 1'b0) begin
      errors++; $display("FAIL legacy_eof: got eof=%b st=%b v=%b want 1 000 0", l_eof, l_status, l_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mii();
    test_rmii_dribble();
    test_back_to_back();
    test_no_sfd();
    test_mode_switch_and_reset();
    test_legacy();
    idle(2);
    checks++;
    if (overlap_cnt !== 0) begin errors++; $display("FAIL valid_eof_overlap: got %0d cycles want 0", overlap_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
